mem_arbiter: RTL

- Shares one single-port unified word memory between the instruction-fetch port and the load/store data port of the core datapath.
- Arbitrates each access, sequences a fixed-latency memory transaction through an FSM, and returns read data or a write acknowledge to the winning requester.
- Sits between the datapath's fetch and data interfaces and the shared memory macro.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_arb_prio.sv | 46 ++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the fetch/data memory arbiter.
// Rev 1.0
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int unsigned C_WORD_SHIFT = 2;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_prio.sv
// mem_arbiter_arb_prio: data-over-fetch priority with a starvation counter; o_gnt = {data, fetch}.
// Rev 1.0
`default_nettype none

module mem_arbiter_arb_prio #(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_idle,
  input  logic       i_if_req,
  input  logic       i_d_req,
  output logic [1:0] o_gnt
);

  localparam int unsigned     C_SW  = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [C_SW-1:0] C_MAX = C_SW'(MAX_STARVE);

  logic [C_SW-1:0] r_starve;
  logic            w_force_if;
  logic            w_gnt_d;
  logic            w_gnt_if;

  // Fetch overrides data only once data has won MAX_STARVE times in a row.
  assign w_force_if = i_if_req && (r_starve == C_MAX);
  assign w_gnt_d    = i_idle && i_d_req && !w_force_if;
  assign w_gnt_if   = i_idle && i_if_req && !w_gnt_d;
  assign o_gnt      = {w_gnt_d, w_gnt_if};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_gnt_if) begin
      r_starve <= '0;
    end else if (w_gnt_d) begin
      if (!i_if_req) begin
        r_starve <= '0;
      end else if (r_starve != C_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency word memory between fetch and load/store ports.
// Rev 1.0 -- optional MEM_ARB_PERF_EN adds the perf_if_stall fetch-stall counter.
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall
`endif
);

  localparam int unsigned     C_LW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [C_LW-1:0] C_LAT_LAST = C_LW'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  owner_t            r_owner;
  logic [C_LW-1:0]   r_lat_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;
  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_lat_last;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_lat_last = (r_lat_cnt == C_LAT_LAST);

  mem_arbiter_arb_prio #(
    .MAX_STARVE (MAX_STARVE)
  ) u_arb_prio (
    .clk      (clk),
    .reset    (reset),
    .i_idle   (w_idle),
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if_gnt = w_gnt[0];
        d_gnt  = w_gnt[1];
        if (|w_gnt) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_we;
        if (w_lat_last) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if_rvalid = (r_owner == OWN_IF);
        d_rvalid  = (r_owner == OWN_D);
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request fields are latched at the grant edge so the memory bus stays stable through ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner    <= OWN_IF;
      r_lat_cnt  <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_lat_cnt <= '0;
          if (w_gnt[1]) begin
            r_owner <= OWN_D;
            r_we    <= d_we;
            r_addr  <= d_addr >> C_WORD_SHIFT;
            r_wdata <= d_wdata;
          end else if (w_gnt[0]) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= if_addr >> C_WORD_SHIFT;
          end
        end
        ST_ACCESS: begin
          if (w_lat_last) begin
            r_lat_cnt <= '0;
            if (r_owner == OWN_IF) begin
              r_if_rdata <= mem_rdata;
            end else begin
              r_d_rdata <= r_we ? 32'h0 : mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_if_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_if_stall <= '0;
    end else if (if_req && !if_gnt && (r_perf_if_stall != 32'hFFFF_FFFF)) begin
      r_perf_if_stall <= r_perf_if_stall + 32'd1;
    end
  end

  assign perf_if_stall = r_perf_if_stall;
`endif

endmodule

`default_nettype wire
